// File: rtl/aliens_pkg.sv
// ---------------------------------------------------------------------------
// aliens_pkg
// Shared definitions for the main-CPU I/O write stage.
//   wdog_state_t      : watchdog FSM state (RUN counting frames, FIRE
//                       holding the system reset).
//   COIN_LSB/COIN_MSB : coin-counter bit positions within the CPU data byte.
//   WDOG_*_DEF        : default watchdog timing.
//   cnt_width()       : counter width for a given limit, at least 1 bit.
// ---------------------------------------------------------------------------
package aliens_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        FIRE = 1'b1
    } wdog_state_t;

    localparam int COIN_LSB          = 5;
    localparam int COIN_MSB          = 6;
    localparam int WDOG_FRAMES_DEF   = 16;
    localparam int WDOG_RST_CYC_DEF  = 64;

    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/aliens_watchdog.sv
// ---------------------------------------------------------------------------
// aliens_watchdog
// Frame-based watchdog. Counts vblank rising edges since the last kick; when
// WDOG_FRAMES edges pass without a kick, it drives wdog_rst high for exactly
// WDOG_RST_CYC clocks, then resumes counting from zero.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous active-high reset
//   kick     in  one-clk watchdog kick (decoded CPU write)
//   vblank   in  video vblank level
//   wdog_rst out system reset request, active high
// ---------------------------------------------------------------------------
module aliens_watchdog
    import aliens_pkg::*;
#(
    parameter int WDOG_FRAMES  = WDOG_FRAMES_DEF,
    parameter int WDOG_RST_CYC = WDOG_RST_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic kick,
    input  logic vblank,
    output logic wdog_rst
);

    localparam int FW = cnt_width(WDOG_FRAMES);
    localparam int RW = cnt_width(WDOG_RST_CYC);
    localparam logic [FW-1:0] FRM_LAST = FW'(WDOG_FRAMES - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(WDOG_RST_CYC - 1);

    wdog_state_t   r_state;
    logic          r_vblank_q;
    logic [FW-1:0] r_frm_cnt;
    logic [RW-1:0] r_rst_cnt;
    logic          w_vblank_rise;

    // Edge is the current level against the previous registered sample.
    assign w_vblank_rise = vblank & ~r_vblank_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_vblank_q <= 1'b0;
            r_frm_cnt  <= '0;
            r_rst_cnt  <= '0;
            wdog_rst   <= 1'b0;
        end else begin
            r_vblank_q <= vblank;
            case (r_state)
                RUN: begin
                    // Kick has priority over a coincident vblank edge.
                    if (kick) begin
                        r_frm_cnt <= '0;
                    end else if (w_vblank_rise) begin
                        if (r_frm_cnt == FRM_LAST) begin
                            r_state   <= FIRE;
                            r_rst_cnt <= '0;
                            wdog_rst  <= 1'b1;
                        end else begin
                            r_frm_cnt <= r_frm_cnt + FW'(1);
                        end
                    end
                end
                FIRE: begin
                    // Kicks and vblank edges are ignored while firing.
                    if (r_rst_cnt == RST_LAST) begin
                        r_state   <= RUN;
                        r_frm_cnt <= '0;
                        wdog_rst  <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RW'(1);
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

// File: rtl/aliens_cpu_io_latch.sv
// ---------------------------------------------------------------------------
// aliens_cpu_io_latch
// Main-CPU I/O write stage behind the address-decode PAL. Turns qualified
// CPU writes into registered ROM bank, coin counter, sound command latch
// with IRQ, and watchdog state.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cpu_wr_stb, cpu_rw  bus data-valid strobe, 1 = read / 0 = write
//   cpu_din[7:0]        CPU data bus
//   bank_cs_n, snd_cs_n, wdog_cs_n  active-low decoded selects
//   vblank              video vblank level
//   snd_rd              sound CPU has read the command latch (one-clk pulse)
//   rom_bank, coin_ctr  bank register outputs
//   snd_cmd, snd_irq    sound command byte and IRQ level
//   wdog_rst            watchdog system reset
//
// Sound handshake: a main-CPU write loads snd_cmd and raises snd_irq; snd_irq
// stays high until the sound CPU pulses snd_rd. A write in the same cycle as
// snd_rd wins, so a fresh command is never lost. There is no queue: a second
// write before snd_rd simply replaces snd_cmd.
// ---------------------------------------------------------------------------
module aliens_cpu_io_latch
    import aliens_pkg::*;
#(
    parameter int WDOG_FRAMES  = WDOG_FRAMES_DEF,
    parameter int WDOG_RST_CYC = WDOG_RST_CYC_DEF,
    parameter int BANK_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_wr_stb,
    input  logic              cpu_rw,
    input  logic [7:0]        cpu_din,
    input  logic              bank_cs_n,
    input  logic              snd_cs_n,
    input  logic              wdog_cs_n,
    input  logic              vblank,
    input  logic              snd_rd,
    output logic [BANK_W-1:0] rom_bank,
    output logic [1:0]        coin_ctr,
    output logic [7:0]        snd_cmd,
    output logic              snd_irq,
    output logic              wdog_rst
);

    logic w_wr;
    logic w_wr_bank;
    logic w_wr_snd;
    logic w_wr_wdog;

    // Each select is qualified independently; overlapping selects from a
    // decode fault simply update every addressed register.
    assign w_wr      = cpu_wr_stb & ~cpu_rw;
    assign w_wr_bank = w_wr & ~bank_cs_n;
    assign w_wr_snd  = w_wr & ~snd_cs_n;
    assign w_wr_wdog = w_wr & ~wdog_cs_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_bank <= '0;
            coin_ctr <= '0;
        end else if (w_wr_bank) begin
            rom_bank <= cpu_din[BANK_W-1:0];
            coin_ctr <= cpu_din[COIN_MSB:COIN_LSB];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snd_cmd <= '0;
            snd_irq <= 1'b0;
        end else if (w_wr_snd) begin
            snd_cmd <= cpu_din;
            snd_irq <= 1'b1;
        end else if (snd_rd) begin
            snd_irq <= 1'b0;
        end
    end

    aliens_watchdog #(
        .WDOG_FRAMES  (WDOG_FRAMES),
        .WDOG_RST_CYC (WDOG_RST_CYC)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .kick     (w_wr_wdog),
        .vblank   (vblank),
        .wdog_rst (wdog_rst)
    );

endmodule

// File: tb/tb_aliens_cpu_io_latch.sv
module tb_aliens_cpu_io_latch;

    localparam int FRAMES  = 4;
    localparam int RST_CYC = 64;
    localparam int BANK_W  = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              cpu_wr_stb = 1'b0;
    logic              cpu_rw     = 1'b1;
    logic [7:0]        cpu_din    = 8'h00;
    logic              bank_cs_n  = 1'b1;
    logic              snd_cs_n   = 1'b1;
    logic              wdog_cs_n  = 1'b1;
    logic              vblank     = 1'b0;
    logic              snd_rd     = 1'b0;
    logic [BANK_W-1:0] rom_bank;
    logic [1:0]        coin_ctr;
    logic [7:0]        snd_cmd;
    logic              snd_irq;
    logic              wdog_rst;

    aliens_cpu_io_latch #(
        .WDOG_FRAMES  (FRAMES),
        .WDOG_RST_CYC (RST_CYC),
        .BANK_W       (BANK_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_wr_stb (cpu_wr_stb),
        .cpu_rw     (cpu_rw),
        .cpu_din    (cpu_din),
        .bank_cs_n  (bank_cs_n),
        .snd_cs_n   (snd_cs_n),
        .wdog_cs_n  (wdog_cs_n),
        .vblank     (vblank),
        .snd_rd     (snd_rd),
        .rom_bank   (rom_bank),
        .coin_ctr   (coin_ctr),
        .snd_cmd    (snd_cmd),
        .snd_irq    (snd_irq),
        .wdog_rst   (wdog_rst)
    );

    // ---------------- reference model state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [BANK_W-1:0] m_bank;
    logic [1:0]        m_coin;
    logic [7:0]        m_cmd;
    logic              m_irq;
    int                m_frames;   // vblank edges seen since last kick / fire

    task automatic model_reset();
        m_bank   = '0;
        m_coin   = '0;
        m_cmd    = '0;
        m_irq    = 1'b0;
        m_frames = 0;
    endtask

    // ---------------- driver ----------------
    task automatic bus_idle();
        cpu_wr_stb = 1'b0;
        cpu_rw     = 1'b1;
        bank_cs_n  = 1'b1;
        snd_cs_n   = 1'b1;
        wdog_cs_n  = 1'b1;
        snd_rd     = 1'b0;
    endtask

    // One bus cycle: drive on a falling edge, captured on the next rising
    // edge, returns on the following falling edge with the model updated.
    task automatic bus_op(input logic stb, input logic rw, input logic b_n,
                          input logic s_n, input logic w_n, input logic rd,
                          input logic [7:0] d);
        logic wr;
        @(negedge clk);
        cpu_wr_stb = stb;
        cpu_rw     = rw;
        bank_cs_n  = b_n;
        snd_cs_n   = s_n;
        wdog_cs_n  = w_n;
        snd_rd     = rd;
        cpu_din    = d;
        @(negedge clk);
        bus_idle();
        wr = stb & ~rw;
        if (wr && !b_n) begin
            m_bank = d[BANK_W-1:0];
            m_coin = d[6:5];
        end
        if (wr && !s_n) begin
            m_cmd = d;
            m_irq = 1'b1;
        end else if (rd) begin
            m_irq = 1'b0;
        end
        if (wr && !w_n) m_frames = 0;
    endtask

    // One vblank rising edge, optionally with a coincident kick. If the model
    // says this edge fires the watchdog, the high time is measured as well.
    task automatic wdog_edge(input logic with_kick, input string tag);
        logic exp_fire;
        int   hi;
        @(negedge clk);
        vblank = 1'b1;
        if (with_kick) begin
            cpu_wr_stb = 1'b1;
            cpu_rw     = 1'b0;
            wdog_cs_n  = 1'b0;
        end
        @(negedge clk);
        bus_idle();
        if (with_kick) m_frames = 0;
        else           m_frames = m_frames + 1;
        exp_fire = (m_frames == FRAMES);
        n_checks++;
        if (wdog_rst !== exp_fire) begin
            n_fail++;
            $display("FAIL %s wdog_rst after edge %0d: got %b expected %b",
                     tag, m_frames, wdog_rst, exp_fire);
        end
        if (exp_fire) begin
            hi = wdog_rst ? 1 : 0;
            if (wdog_rst) begin
                for (int i = 0; i < 4 * RST_CYC; i++) begin
                    @(negedge clk);
                    if (wdog_rst) hi++;
                    else break;
                end
            end
            n_checks++;
            if (hi != RST_CYC) begin
                n_fail++;
                $display("FAIL %s wdog_rst high cycles: got %0d expected %0d",
                         tag, hi, RST_CYC);
            end
            m_frames = 0;
        end
        @(negedge clk);
        vblank = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rom_bank, coin_ctr, snd_cmd, snd_irq, wdog_rst} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got bank=%0h coin=%0h cmd=%0h irq=%b wdog=%b expected all zero",
                     rom_bank, coin_ctr, snd_cmd, snd_irq, wdog_rst);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rom_bank, coin_ctr, snd_cmd, snd_irq, wdog_rst} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got bank=%0h coin=%0h cmd=%0h irq=%b wdog=%b expected all zero",
                     rom_bank, coin_ctr, snd_cmd, snd_irq, wdog_rst);
        end
    endtask

    task automatic test_bank();
        bus_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h6B);
        n_checks++;
        if (rom_bank !== 5'h0B || coin_ctr !== 2'b11) begin
            n_fail++;
            $display("FAIL bank_write: got bank=%0h coin=%0h expected bank=0b coin=3", rom_bank, coin_ctr);
        end
        // Read cycle with the select active: no effect.
        bus_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h14);
        n_checks++;
        if (rom_bank !== 5'h0B || coin_ctr !== 2'b11) begin
            n_fail++;
            $display("FAIL bank_read_ignored: got bank=%0h coin=%0h expected bank=0b coin=3", rom_bank, coin_ctr);
        end
        // Select and write direction without the strobe: no effect.
        bus_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h14);
        n_checks++;
        if (rom_bank !== 5'h0B || coin_ctr !== 2'b11) begin
            n_fail++;
            $display("FAIL bank_no_strobe: got bank=%0h coin=%0h expected bank=0b coin=3", rom_bank, coin_ctr);
        end
    endtask

    task automatic test_sound();
        bus_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h42);
        n_checks++;
        if (snd_cmd !== 8'h42 || snd_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL snd_write: got cmd=%0h irq=%b expected cmd=42 irq=1", snd_cmd, snd_irq);
        end
        bus_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (snd_cmd !== 8'h42 || snd_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL snd_read_ack: got cmd=%0h irq=%b expected cmd=42 irq=0", snd_cmd, snd_irq);
        end
        bus_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
        bus_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
        n_checks++;
        if (snd_cmd !== 8'h22 || snd_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL snd_overwrite: got cmd=%0h irq=%b expected cmd=22 irq=1", snd_cmd, snd_irq);
        end
    endtask

    task automatic test_back_to_back();
        // snd_irq is 1 here; write and read in the same cycle.
        bus_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h99);
        n_checks++;
        if (snd_cmd !== 8'h99 || snd_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL snd_write_vs_read: got cmd=%0h irq=%b expected cmd=99 irq=1", snd_cmd, snd_irq);
        end
    endtask

    task automatic test_random_bus();
        logic stb, rw, b_n, s_n, w_n, rd;
        logic [7:0] d;
        for (int i = 0; i < 60; i++) begin
            stb = 1'($urandom_range(0, 1));
            rw  = ($urandom_range(0, 3) == 0);
            b_n = 1'($urandom_range(0, 1));
            s_n = 1'($urandom_range(0, 1));
            w_n = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            d   = 8'($urandom_range(0, 255));
            bus_op(stb, rw, b_n, s_n, w_n, rd, d);
            n_checks++;
            if (rom_bank !== m_bank || coin_ctr !== m_coin) begin
                n_fail++;
                $display("FAIL rand_bank[%0d]: got bank=%0h coin=%0h expected bank=%0h coin=%0h",
                         i, rom_bank, coin_ctr, m_bank, m_coin);
            end
            n_checks++;
            if (snd_cmd !== m_cmd || snd_irq !== m_irq) begin
                n_fail++;
                $display("FAIL rand_snd[%0d]: got cmd=%0h irq=%b expected cmd=%0h irq=%b",
                         i, snd_cmd, snd_irq, m_cmd, m_irq);
            end
            n_checks++;
            if (wdog_rst !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_wdog[%0d]: got %b expected 0", i, wdog_rst);
            end
        end
    endtask

    task automatic test_wdog_fire();
        for (int i = 0; i < FRAMES; i++) wdog_edge(1'b0, "wdog_fire");
    endtask

    task automatic test_wdog_kick();
        for (int i = 0; i < FRAMES - 1; i++) wdog_edge(1'b0, "wdog_kick_pre");
        wdog_edge(1'b1, "wdog_kick_edge");
        for (int i = 0; i < FRAMES; i++) wdog_edge(1'b0, "wdog_kick_post");
    endtask

    task automatic test_wdog_reset_mid_fire();
        bus_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7F);
        for (int i = 0; i < FRAMES - 1; i++) wdog_edge(1'b0, "midfire_pre");
        @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wdog_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL midfire_enter: got %b expected 1", wdog_rst);
        end
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({rom_bank, coin_ctr, snd_cmd, snd_irq, wdog_rst} !== '0) begin
            n_fail++;
            $display("FAIL midfire_async_reset: got bank=%0h coin=%0h cmd=%0h irq=%b wdog=%b expected all zero",
                     rom_bank, coin_ctr, snd_cmd, snd_irq, wdog_rst);
        end
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < FRAMES; i++) wdog_edge(1'b0, "midfire_post");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus_idle();
        model_reset();
        test_reset();
        test_bank();
        test_sound();
        test_back_to_back();
        test_random_bus();
        test_wdog_fire();
        test_wdog_kick();
        test_wdog_reset_mid_fire();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
